sb_multi_timeout_timer: RTL and testbench

SB_MULTI_TIMEOUT_TIMER -- requirements
Module: sb_multi_timeout_timer

---
 rtl/sb_multi_timeout_timer.sv | 139 +++++++++++++
 tb/tb_sb_multi_timeout_timer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sb_multi_timeout_timer.sv
`default_nettype none
// sb_multi_timeout_timer: NUM_CH independent millisecond timeout channels (IDLE/RUN/TIMEOUT each).
// Rev 1.0 -- outputs are registered decodes of each channel's state, one edge behind the FSM.
module sb_multi_timeout_timer #(
   parameter int NUM_CH     = 4,
   parameter int CLK_PER_MS = 100,
   parameter int TIMEOUT_MS = 8,
   parameter int PULSE_MODE = 0
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [NUM_CH-1:0]     i_start,
   input  logic [NUM_CH-1:0]     i_stop,
   input  logic [NUM_CH-1:0]     i_pause,
   input  logic [NUM_CH-1:0]     i_force_to,
   input  logic [7:0]            i_cfg_timeout_ms,
   output logic [NUM_CH-1:0]     o_time_out,
   output logic [NUM_CH-1:0]     o_active,
   output logic                  o_any_time_out,
   output logic [NUM_CH*8-1:0]   o_elapsed_ms
);
   localparam int            TW        = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
   localparam logic [TW-1:0] TICK_MAX  = TW'(CLK_PER_MS - 1);
   localparam logic [7:0]    DEF_LIMIT = 8'(TIMEOUT_MS);
   localparam logic [1:0]    ST_IDLE   = 2'd0;
   localparam logic [1:0]    ST_RUN    = 2'd1;
   localparam logic [1:0]    ST_TO     = 2'd2;

   logic [NUM_CH-1:0] to_dec_all;
   logic              any_q;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [1:0]    state, state_nxt;
      logic [TW-1:0] tick, tick_nxt;
      logic [7:0]    ms, ms_nxt;
      logic [7:0]    limit, limit_nxt;
      logic          to_dec, act_dec;
      logic [7:0]    el_dec;
      logic          to_q, act_q;
      logic [7:0]    el_q;

      always_ff @(posedge i_clk) begin
         if (i_rst) begin
            state <= ST_IDLE;
            tick  <= '0;
            ms    <= '0;
            limit <= '0;
            to_q  <= 1'b0;
            act_q <= 1'b0;
            el_q  <= '0;
         end else begin
            state <= state_nxt;
            tick  <= tick_nxt;
            ms    <= ms_nxt;
            limit <= limit_nxt;
            to_q  <= to_dec;
            act_q <= act_dec;
            el_q  <= el_dec;
         end
      end

      // Priority: force timeout, stop, start, then pause/count.
      always_comb begin
         state_nxt = state;
         tick_nxt  = tick;
         ms_nxt    = ms;
         limit_nxt = limit;
         if (i_force_to[c]) begin
            state_nxt = ST_TO;
            tick_nxt  = '0;
            ms_nxt    = '0;
         end else if (i_stop[c]) begin
            state_nxt = ST_IDLE;
            tick_nxt  = '0;
            ms_nxt    = '0;
         end else if (i_start[c]) begin
            state_nxt = ST_RUN;
            tick_nxt  = '0;
            ms_nxt    = '0;
            limit_nxt = (i_cfg_timeout_ms == 8'd0) ? DEF_LIMIT : i_cfg_timeout_ms;
         end else begin
            case (state)
               ST_RUN: begin
                  if (!i_pause[c]) begin
                     if (tick == TICK_MAX) begin
                        tick_nxt = '0;
                        if (ms == limit - 8'd1) begin
                           state_nxt = ST_TO;
                           ms_nxt    = '0;
                        end else begin
                           ms_nxt = ms + 8'd1;
                        end
                     end else begin
                        tick_nxt = tick + TW'(1);
                     end
                  end
               end
               ST_TO: begin
                  if (PULSE_MODE != 0) begin
                     state_nxt = ST_IDLE;
                  end
               end
               ST_IDLE: begin
                  state_nxt = ST_IDLE;
               end
               default: begin
                  state_nxt = ST_IDLE;
                  tick_nxt  = '0;
                  ms_nxt    = '0;
               end
            endcase
         end
      end

      always_comb begin
         to_dec  = (state == ST_TO);
         act_dec = (state == ST_RUN);
         el_dec  = act_dec ? ms : 8'd0;
      end

      assign to_dec_all[c]         = to_dec;
      assign o_time_out[c]         = to_q;
      assign o_active[c]           = act_q;
      assign o_elapsed_ms[8*c +: 8] = el_q;
   end

   // Registered from the same decode as o_time_out so both change on the same edge.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         any_q <= 1'b0;
      end else begin
         any_q <= |to_dec_all;
      end
   end

   assign o_any_time_out = any_q;

endmodule
`default_nettype wire

// File: tb/tb_sb_multi_timeout_timer.sv
`default_nettype none
// tb_sb_multi_timeout_timer: directed stimulus with a queue of expected outputs keyed by edge number.
module tb_sb_multi_timeout_timer;
   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  start, stop, pause, force_to;
   logic [7:0]  cfg;
   logic [3:0]  to_m, act_m, to_p, act_p;
   logic        any_m, any_p;
   logic [31:0] el_m, el_p;

   int cyc     = 0;
   int base    = 0;
   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      int    at;
      int    dut;
      int    fld;
      int    ch;
      int    val;
      string name;
   } exp_t;
   exp_t q[$];

   sb_multi_timeout_timer #(.NUM_CH(4), .CLK_PER_MS(100), .TIMEOUT_MS(8), .PULSE_MODE(0)) dut_m (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop), .i_pause(pause),
      .i_force_to(force_to), .i_cfg_timeout_ms(cfg), .o_time_out(to_m), .o_active(act_m),
      .o_any_time_out(any_m), .o_elapsed_ms(el_m));

   sb_multi_timeout_timer #(.NUM_CH(4), .CLK_PER_MS(100), .TIMEOUT_MS(8), .PULSE_MODE(1)) dut_p (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop), .i_pause(pause),
      .i_force_to(force_to), .i_cfg_timeout_ms(cfg), .o_time_out(to_p), .o_active(act_p),
      .o_any_time_out(any_p), .o_elapsed_ms(el_p));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // fld: 0 time_out vector, 1 active vector, 2 any_time_out, 3 elapsed_ms of channel ch
   function automatic int actual(input int dut, input int fld, input int ch);
      logic [3:0]  tv, av;
      logic        anyv;
      logic [31:0] ev;
      if (dut == 0) begin
         tv = to_m; av = act_m; anyv = any_m; ev = el_m;
      end else begin
         tv = to_p; av = act_p; anyv = any_p; ev = el_p;
      end
      case (fld)
         0:       return int'(tv);
         1:       return int'(av);
         2:       return int'(anyv);
         default: return int'(ev[ch*8 +: 8]);
      endcase
   endfunction

   function automatic void chk(input int k, input int dut, input int fld, input int ch,
                               input int val, input string name);
      exp_t e;
      e.at = base + k; e.dut = dut; e.fld = fld; e.ch = ch; e.val = val; e.name = name;
      q.push_back(e);
   endfunction

   // Monitor: compare every expectation due after the edge just taken.
   always @(negedge clk) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
         if (q[i].at == cyc) begin
            int a;
            a = actual(q[i].dut, q[i].fld, q[i].ch);
            n_tests++;
            if (a !== q[i].val) begin
               n_fail++;
               $display("FAIL %s at edge %0d: got %0d expected %0d", q[i].name, cyc - base, a, q[i].val);
            end
            q.delete(i);
         end
      end
   end

   // Returns so that inputs written now are sampled at relative edge k.
   task automatic wait_before_edge(input int k);
      int guard = 0;
      while (cyc < base + k - 1 && guard < 3000) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 3000) begin
         n_tests++;
         n_fail++;
         $display("FAIL wait_bound edge %0d: got cyc %0d expected %0d", k, cyc, base + k - 1);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; start = '0; stop = '0; pause = '0; force_to = '0; cfg = '0;
      base = cyc;
      chk(1, 0, 0, 0, 0, "rst_to");
      chk(1, 0, 1, 0, 0, "rst_act");
      chk(1, 0, 2, 0, 0, "rst_any");
      chk(1, 0, 3, 0, 0, "rst_el0");
      chk(1, 1, 0, 0, 0, "rst_to_p");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic start_ch(input logic [3:0] m, input logic [7:0] c);
      @(negedge clk);
      start = m;
      cfg   = c;
      @(posedge clk);
      #1;
      base  = cyc;
      start = '0;
   endtask

   initial begin
      rst = 1'b1; start = '0; stop = '0; pause = '0; force_to = '0; cfg = '0;

      // Defaults, cfg=0 -> 8 ms limit on channel 0
      do_reset();
      start_ch(4'b0001, 8'd0);
      chk(1,   0, 1, 0, 1, "s1_act");
      chk(1,   0, 3, 0, 0, "s1_el_1");
      chk(100, 0, 3, 0, 0, "s1_el_100");
      chk(101, 0, 3, 0, 1, "s1_el_101");
      chk(800, 0, 3, 0, 7, "s1_el_800");
      chk(800, 0, 0, 0, 0, "s1_to_800");
      chk(801, 0, 0, 0, 1, "s1_to_801");
      chk(801, 0, 2, 0, 1, "s1_any_801");
      chk(801, 0, 1, 0, 0, "s1_act_801");
      chk(801, 0, 3, 0, 0, "s1_el_801");
      chk(850, 0, 0, 0, 1, "s1_sticky");
      wait_before_edge(852);

      // Pause 50 cycles on ch1, cfg change mid-run ignored
      do_reset();
      start_ch(4'b0010, 8'd3);
      chk(1,   0, 1, 0, 2, "s2_act");
      chk(175, 0, 1, 0, 2, "s2_act_paused");
      chk(175, 0, 3, 1, 1, "s2_el_paused");
      chk(251, 0, 3, 1, 2, "s2_el_251");
      chk(350, 0, 0, 0, 0, "s2_to_350");
      chk(351, 0, 0, 0, 2, "s2_to_351");
      chk(351, 0, 2, 0, 1, "s2_any_351");
      wait_before_edge(50);  cfg = 8'd1;
      wait_before_edge(150); pause = 4'b0010;
      wait_before_edge(200); pause = 4'b0000;
      wait_before_edge(353);

      // Stop ch2 at 500, restart at 600 with cfg=2
      do_reset();
      start_ch(4'b0100, 8'd0);
      chk(500, 0, 1, 0, 4, "s3_act_500");
      chk(500, 0, 3, 2, 4, "s3_el_500");
      chk(501, 0, 1, 0, 0, "s3_act_501");
      chk(501, 0, 3, 2, 0, "s3_el_501");
      chk(501, 0, 0, 0, 0, "s3_to_501");
      chk(601, 0, 1, 0, 4, "s3_restart_act");
      chk(800, 0, 0, 0, 0, "s3_to_800");
      chk(801, 0, 0, 0, 4, "s3_to_801");
      wait_before_edge(500); stop = 4'b0100;
      wait_before_edge(501); stop = 4'b0000;
      wait_before_edge(600); start = 4'b0100; cfg = 8'd2;
      wait_before_edge(601); start = 4'b0000;
      wait_before_edge(803);

      // force_to beats stop; stop beats start
      do_reset();
      start_ch(4'b1000, 8'd0);
      chk(50, 0, 1, 0, 8, "s4_act_50");
      chk(51, 0, 0, 0, 8, "s4_force_to");
      chk(51, 0, 2, 0, 1, "s4_any_51");
      chk(51, 0, 1, 0, 0, "s4_act_51");
      chk(59, 0, 0, 0, 8, "s4_sticky");
      chk(61, 0, 0, 0, 0, "s4_startstop_to");
      chk(61, 0, 1, 0, 0, "s4_startstop_act");
      chk(61, 0, 2, 0, 0, "s4_any_61");
      wait_before_edge(50); force_to = 4'b1000; stop = 4'b1000;
      wait_before_edge(51); force_to = 4'b0000; stop = 4'b0000;
      wait_before_edge(60); start = 4'b1000; stop = 4'b1000;
      wait_before_edge(61); start = 4'b0000; stop = 4'b0000;
      wait_before_edge(63);

      // Reset mid-run overrides a coincident start
      do_reset();
      start_ch(4'b0011, 8'd0);
      chk(399, 0, 1, 0, 3, "s5_act_399");
      chk(399, 0, 3, 1, 3, "s5_el_399");
      chk(400, 0, 1, 0, 0, "s5_rst_act");
      chk(400, 0, 3, 0, 0, "s5_rst_el0");
      chk(400, 0, 3, 1, 0, "s5_rst_el1");
      chk(401, 0, 1, 0, 0, "s5_rst_override");
      chk(402, 0, 1, 0, 4, "s5_first_start");
      chk(900, 0, 0, 0, 0, "s5_no_to");
      chk(900, 0, 1, 0, 4, "s5_act_900");
      wait_before_edge(400); rst = 1'b1; start = 4'b0100;
      wait_before_edge(401); rst = 1'b0;
      wait_before_edge(402); start = 4'b0000;
      wait_before_edge(902);

      // Pulse mode, cfg=1
      do_reset();
      start_ch(4'b0001, 8'd1);
      chk(100, 1, 0, 0, 0, "s6_to_100");
      chk(101, 1, 0, 0, 1, "s6_pulse");
      chk(101, 1, 2, 0, 1, "s6_any_101");
      chk(102, 1, 0, 0, 0, "s6_pulse_end");
      chk(102, 1, 2, 0, 0, "s6_any_102");
      chk(102, 1, 1, 0, 0, "s6_idle");
      chk(102, 0, 0, 0, 1, "s6_sticky_main");
      chk(120, 1, 0, 0, 0, "s6_to_120");
      wait_before_edge(122);

      repeat (3) @(negedge clk);
      foreach (q[i]) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: got unchecked expected checked", q[i].name);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
